// File: rtl/fp16_acc_if.sv
// fp16_acc_if: term stream into the accumulator and the running-sum status out of it.
//   in_valid/in_data/in_last : binary16 term offered by the upstream multiplier
//   in_ready                 : accumulator can take a term this cycle
//   acc_out/cnt/ovf          : running sum, number of terms in it, sticky overflow
//   out_valid                : one-cycle pulse when a sum closed by in_last is final
interface fp16_acc_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_last;
  logic             in_ready;
  logic [15:0]      acc_out;
  logic             out_valid;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, acc_out, out_valid, cnt, ovf
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, acc_out, out_valid, cnt, ovf
  );
endinterface

// File: rtl/fp16_acc.sv
// fp16_acc: multi-cycle binary16 accumulator (IDLE -> ALIGN -> ADD -> NORM).
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear of sum, count, flag and sequencer
//   bus        : slave side of fp16_acc_if (term in, running sum out)
// Rounding is toward zero; zero/subnormal inputs count as +0 and tiny
// results flush to +0. Once ovf is set the sum is frozen until a new sum starts.
module fp16_acc #(
  parameter int unsigned CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr,
  fp16_acc_if.slave bus
);
  localparam int unsigned DW = 16;
  localparam int unsigned EW = 5;
  localparam int unsigned MW = 11;
  localparam int unsigned SW = 12;
  localparam int unsigned XW = 7;

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    term_q, term_d;
  logic             last_q, last_d;
  logic             zero_base_q, zero_base_d;
  logic             fresh_q, fresh_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [EW-1:0]    exp_q, exp_d;
  logic [MW-1:0]    m_hi_q, m_hi_d;
  logic [MW-1:0]    m_lo_q, m_lo_d;
  logic             sign_q, sign_d;
  logic             sub_q, sub_d;
  logic             inf_q, inf_d;
  logic             inf_sign_q, inf_sign_d;
  logic [SW-1:0]    sum_q, sum_d;

  // Alignment and normalisation helpers
  logic [DW-1:0] op_a, op_b;
  logic [EW-1:0] e_a, e_b, e_hi, e_lo, diff;
  logic [MW-1:0] m_a, m_b, m_hi, m_lo;
  logic          s_hi, a_ge;
  logic [3:0]    lead, sh;
  logic [XW-1:0] e_inc, e_res;
  logic          flush, over;
  logic [9:0]    frac;

  // Next-state, datapath and output logic
  always_comb begin
    state_d     = state_q;
    term_d      = term_q;
    last_d      = last_q;
    zero_base_d = zero_base_q;
    fresh_d     = fresh_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    exp_d       = exp_q;
    m_hi_d      = m_hi_q;
    m_lo_d      = m_lo_q;
    sign_d      = sign_q;
    sub_d       = sub_q;
    inf_d       = inf_q;
    inf_sign_d  = inf_sign_q;
    sum_d       = sum_q;

    // Operand decode: the first term of a new sum adds onto +0
    op_a = zero_base_q ? '0 : acc_q;
    op_b = term_q;
    e_a  = op_a[14:10];
    e_b  = op_b[14:10];
    m_a  = (e_a == '0) ? '0 : {1'b1, op_a[9:0]};
    m_b  = (e_b == '0) ? '0 : {1'b1, op_b[9:0]};
    a_ge = (e_a > e_b) || ((e_a == e_b) && (m_a >= m_b));
    e_hi = a_ge ? e_a : e_b;
    e_lo = a_ge ? e_b : e_a;
    m_hi = a_ge ? m_a : m_b;
    m_lo = a_ge ? m_b : m_a;
    s_hi = a_ge ? op_a[15] : op_b[15];
    diff = e_hi - e_lo;

    // Leading-one position of the raw sum; shift brings it to bit 11
    lead = '0;
    for (int i = 0; i < SW; i++) begin
      if (sum_q[i]) lead = 4'(i);
    end
    sh    = 4'd11 - lead;
    frac  = 10'((sum_q << sh) >> 1);
    e_inc = XW'(exp_q) + XW'(1);
    e_res = e_inc - XW'(sh);
    flush = (sum_q == '0) || (e_inc <= XW'(sh));
    over  = !flush && (e_res >= XW'(31));

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          term_d      = bus.in_data;
          last_d      = bus.in_last;
          zero_base_d = fresh_q;
          fresh_d     = 1'b0;
          if (fresh_q) begin
            cnt_d = CNT_W'(1);
            ovf_d = 1'b0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        exp_d      = e_hi;
        m_hi_d     = m_hi;
        m_lo_d     = (diff >= EW'(12)) ? '0 : (m_lo >> diff);
        sign_d     = s_hi;
        sub_d      = op_a[15] ^ op_b[15];
        inf_d      = (e_b == '1);
        inf_sign_d = op_b[15];
        state_d    = ADD;
      end
      ADD: begin
        // m_hi >= aligned m_lo, so the difference never goes negative
        sum_d   = sub_q ? (SW'(m_hi_q) - SW'(m_lo_q)) : (SW'(m_hi_q) + SW'(m_lo_q));
        state_d = NORM;
      end
      NORM: begin
        if (!ovf_q) begin
          if (inf_q) begin
            acc_d = {inf_sign_q, 15'h7C00};
            ovf_d = 1'b1;
          end else if (flush) begin
            acc_d = '0;
          end else if (over) begin
            acc_d = {sign_q, 15'h7C00};
            ovf_d = 1'b1;
          end else begin
            acc_d = {sign_q, 5'(e_res), frac};
          end
        end
        if (last_q) begin
          out_valid_d = 1'b1;
          fresh_d     = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Synchronous clear wins over everything, including an accept
    if (clr) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      fresh_d     = 1'b0;
    end

    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      term_q      <= '0;
      last_q      <= 1'b0;
      zero_base_q <= 1'b0;
      fresh_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      exp_q       <= '0;
      m_hi_q      <= '0;
      m_lo_q      <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      inf_q       <= 1'b0;
      inf_sign_q  <= 1'b0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      term_q      <= term_d;
      last_q      <= last_d;
      zero_base_q <= zero_base_d;
      fresh_q     <= fresh_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      exp_q       <= exp_d;
      m_hi_q      <= m_hi_d;
      m_lo_q      <= m_lo_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      inf_q       <= inf_d;
      inf_sign_q  <= inf_sign_d;
      sum_q       <= sum_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.acc_out   = acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cnt       = cnt_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fp16_acc.sv
// tb_fp16_acc: directed bench for fp16_acc with a value-level reference model.
module tb_fp16_acc;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;
  int   pulses = 0;
  bit   check_en = 1'b0;

  fp16_acc_if #(.CNT_W(CNT_W)) bus();

  fp16_acc #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Reference: sum of two binary16 values; smaller operand truncated to the
  // larger one's grid, result truncated toward zero, tiny -> +0, huge -> inf.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, eh, el, mh, ml, s, e;
    logic sh, sl;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
    mb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
    if (ea > eb || (ea == eb && ma >= mb)) begin
      eh = ea; mh = ma; sh = a[15]; el = eb; ml = mb; sl = b[15];
    end else begin
      eh = eb; mh = mb; sh = b[15]; el = ea; ml = ma; sl = a[15];
    end
    ml = (eh - el >= 12) ? 0 : (ml >> (eh - el));
    s  = (sh == sl) ? mh + ml : mh - ml;
    if (s == 0) return 16'h0000;
    e = eh;
    while (s >= 2048) begin s = s / 2; e++; end
    while (s < 1024) begin s = s * 2; e--; end
    if (e >= 31) return {sh, 15'h7C00};
    if (e < 1) return 16'h0000;
    return {sh, 5'(e), 10'(s - 1024)};
  endfunction

  // Cycle-level expectation: term result lands 3 edges after its accept
  logic [15:0]      m_acc = '0;
  logic [15:0]      m_term = '0;
  logic [15:0]      m_base = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_ovf = 1'b0;
  logic             m_ov = 1'b0;
  logic             m_rdy = 1'b1;
  logic             m_fresh = 1'b0;
  logic             m_last = 1'b0;
  int               m_busy = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = '0; m_cnt = '0; m_ovf = 1'b0; m_ov = 1'b0;
      m_rdy = 1'b1; m_fresh = 1'b0; m_busy = 0;
    end else begin
      m_ov = 1'b0;
      if (clr) begin
        m_acc = '0; m_cnt = '0; m_ovf = 1'b0; m_rdy = 1'b1; m_fresh = 1'b0; m_busy = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          if (!m_ovf) begin
            if (m_term[14:10] == 5'h1F) begin
              m_acc = {m_term[15], 15'h7C00};
              m_ovf = 1'b1;
            end else begin
              m_acc = fp_add(m_base, m_term);
              if (m_acc[14:0] == 15'h7C00) m_ovf = 1'b1;
            end
          end
          if (m_last) begin m_ov = 1'b1; m_fresh = 1'b1; end
          m_rdy = 1'b1;
        end
      end else if (bus.in_valid && m_rdy) begin
        m_term = bus.in_data;
        m_last = bus.in_last;
        m_base = m_fresh ? 16'h0000 : m_acc;
        if (m_fresh) begin
          m_cnt = CNT_W'(1); m_ovf = 1'b0;
        end else if (m_cnt != '1) begin
          m_cnt = m_cnt + CNT_W'(1);
        end
        m_fresh = 1'b0;
        m_busy  = 3;
        m_rdy   = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
      chk("acc_out", 32'(bus.acc_out), 32'(m_acc));
      chk("cnt", 32'(bus.cnt), 32'(m_cnt));
      chk("ovf", 32'(bus.ovf), 32'(m_ovf));
      chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
      if (bus.out_valid) pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    while (!bus.in_ready && n < 20) begin step(); n++; end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    step();
    // Garbage after the accept edge must not leak into the sum
    bus.in_valid = 1'b0;
    bus.in_data  = 16'hFFFF;
    bus.in_last  = ~l;
  endtask

  task automatic settle();
    repeat (6) step();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    #2 rst_n = 1'b0;
    check_en = 1'b1;
    repeat (2) step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_acc", 32'(bus.acc_out), 32'h0000);
    rst_n = 1'b1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    chk("model_1p1", 32'(fp_add(16'h3C00, 16'h3C00)), 32'h4000);
    chk("model_sub", 32'(fp_add(16'h3C00, 16'hB000)), 32'h3B00);
    chk("model_uflow", 32'(fp_add(16'h0600, 16'h8400)), 32'h0000);

    // 1 + 1
    pulses = 0;
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b1);
    settle();
    chk("s1_acc", 32'(bus.acc_out), 32'h4000);
    chk("s1_cnt", 32'(bus.cnt), 32'd2);
    chk("s1_pulses", 32'(pulses), 32'd1);

    // 1 + 2 + 3 (fresh sum after the pulse)
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b0);
    send(16'h4200, 1'b1);
    settle();
    chk("s2_acc", 32'(bus.acc_out), 32'h4600);
    chk("s2_cnt", 32'(bus.cnt), 32'd3);
    chk("s2_ovf", 32'(bus.ovf), 32'd0);

    // Exact cancellation then restart
    send(16'h3E00, 1'b0);
    send(16'hBE00, 1'b1);
    settle();
    chk("s3_zero", 32'(bus.acc_out), 32'h0000);
    send(16'h3C00, 1'b0);
    settle();
    chk("s3_acc", 32'(bus.acc_out), 32'h3C00);
    chk("s3_cnt", 32'(bus.cnt), 32'd1);

    // Overflow is sticky and freezes the sum
    do_clr();
    send(16'h7BFF, 1'b0);
    send(16'h7BFF, 1'b0);
    settle();
    chk("s4_inf", 32'(bus.acc_out), 32'h7C00);
    chk("s4_ovf", 32'(bus.ovf), 32'd1);
    send(16'h3C00, 1'b1);
    settle();
    chk("s4_hold", 32'(bus.acc_out), 32'h7C00);
    chk("s4_cnt", 32'(bus.cnt), 32'd3);

    // Infinity input forces signed inf
    send(16'h3C00, 1'b0);
    send(16'hFC00, 1'b0);
    settle();
    chk("s4_ninf", 32'(bus.acc_out), 32'hFC00);
    chk("s4_novf", 32'(bus.ovf), 32'd1);

    // Alignment boundary and subnormal input
    do_clr();
    send(16'h3C00, 1'b0);
    send(16'h0C00, 1'b1);
    settle();
    chk("s5_trunc", 32'(bus.acc_out), 32'h3C00);
    send(16'h3C00, 1'b0);
    send(16'h0200, 1'b1);
    settle();
    chk("s5_subn", 32'(bus.acc_out), 32'h3C00);

    // Alignment with borrow, underflow flush, sign handling
    send(16'h3C00, 1'b0);
    send(16'hB000, 1'b1);
    settle();
    chk("s6_sub", 32'(bus.acc_out), 32'h3B00);
    send(16'h0600, 1'b0);
    send(16'h8400, 1'b1);
    settle();
    chk("s6_flush", 32'(bus.acc_out), 32'h0000);
    send(16'h4500, 1'b0);
    send(16'hC600, 1'b1);
    settle();
    chk("s6_neg", 32'(bus.acc_out), 32'hBC00);

    // clr one cycle after an accept aborts the term
    send(16'h3C00, 1'b1);
    settle();
    pulses = 0;
    send(16'h4000, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("s7_clr_acc", 32'(bus.acc_out), 32'h0000);
    chk("s7_clr_cnt", 32'(bus.cnt), 32'd0);
    chk("s7_clr_rdy", 32'(bus.in_ready), 32'd1);
    settle();
    chk("s7_clr_pulses", 32'(pulses), 32'd0);

    // Async reset one cycle after an accept
    send(16'h3C00, 1'b0);
    settle();
    pulses = 0;
    send(16'h4000, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("s8_rst_acc", 32'(bus.acc_out), 32'h0000);
    chk("s8_rst_cnt", 32'(bus.cnt), 32'd0);
    step();
    rst_n = 1'b1;
    chk("s8_rst_rdy", 32'(bus.in_ready), 32'd1);
    settle();
    chk("s8_rst_pulses", 32'(pulses), 32'd0);
    chk("s8_rst_acc2", 32'(bus.acc_out), 32'h0000);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fp16_acc.md
FP16_ACC -- requirements
Module: fp16_acc

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the accumulated-term counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port clr  input  1  synchronous clear of accumulator, counter and FSM.
REQ-005 SHALL have port in_valid  input  1  in_data holds a product from the upstream fmul stage.
REQ-006 SHALL have port in_data  input  16  IEEE-754 binary16 term: sign[15], exp[14:10], frac[9:0].
REQ-007 SHALL have port in_last  input  1  the accepted term closes the current sum.
REQ-008 SHALL have port in_ready  output  1  block can accept a term this cycle.
REQ-009 SHALL have port acc_out  output  16  current binary16 running sum.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse when a sum closed by in_last is final.
REQ-011 SHALL have port cnt  output  CNT_W  number of terms in the current sum; saturates at all-ones.
REQ-012 SHALL have port ovf  output  1  sticky flag for overflow or an infinity/NaN input.

Function
REQ-013 SHALL implement FSM states IDLE, ALIGN, ADD and NORM; in_ready SHALL be 1 only in IDLE.
REQ-014 SHALL accept a term on any rising edge with in_valid=1 and in_ready=1, then move to ALIGN.
REQ-015 SHALL sequence ALIGN->ADD->NORM->IDLE unconditionally; term accepted on edge T updates acc_out on edge T+3, throughput one term per 4 cycles.
REQ-016 ALIGN SHALL restore hidden bit, compare exponents, right-shift the smaller mantissa by the difference with shifted-out bits discarded; difference >= 12 SHALL contribute zero.
REQ-017 ADD SHALL add or subtract the 12-bit mantissas by sign; result sign follows the larger magnitude.
REQ-018 NORM SHALL normalise in one cycle (leading-one detect plus shift), round toward zero, and write acc_out.
REQ-019 Inputs with exp=0 (zero/subnormal) SHALL be treated as +0; results with exp < 1 SHALL flush to 16'h0000.
REQ-020 Exact cancellation SHALL give 16'h0000 (+0).
REQ-021 A result exponent >= 31 SHALL give 16'h7C00/16'hFC00 by sign and set ovf.
REQ-022 An input with exp=31 SHALL set ovf and force acc_out to 16'h7C00/16'hFC00 by input sign; further terms SHALL leave acc_out unchanged until clear.
REQ-023 cnt SHALL increment on each accepting edge.
REQ-024 If the accepted term had in_last=1, out_valid SHALL be 1 for exactly the cycle after the NORM edge; acc_out and cnt SHALL then hold.
REQ-025 The first term accepted after an out_valid pulse SHALL start a fresh sum: accumulator treated as +0, cnt=1, ovf cleared.
REQ-026 in_data and in_last SHALL be sampled only on the accepting edge; later changes SHALL have no effect.
REQ-027 clr=1 SHALL override all else on that edge: aborts any in-flight term, acc_out=0, cnt=0, ovf=0, out_valid=0, state IDLE; in_valid is ignored on that edge.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, acc_out=16'h0000, cnt=0, ovf=0, out_valid=0 and drop any in-flight term.
REQ-029 in_ready SHALL be 1 while rst_n=0 and on the first cycle after release; no term SHALL be accepted while rst_n=0.

Verification
REQ-030 SHALL check: after reset, 3C00 then 3C00 (last) -> acc_out=4000, cnt=2, out_valid pulses once, in_ready low for 3 cycles after each accept.
REQ-031 SHALL check: 3C00, 4000, 4200 (last) -> acc_out=4600, cnt=3, ovf=0.
REQ-032 SHALL check: 3E00 then BE00 (last) -> acc_out=0000; next 3C00 -> acc_out=3C00, cnt=1.
REQ-033 SHALL check: 7BFF then 7BFF -> acc_out=7C00, ovf=1; then 3C00 -> acc_out stays 7C00.
REQ-034 SHALL check: 3C00 then 0C00 -> acc_out=3C00 (truncated); 3C00 then 0200 (subnormal) -> 3C00.
REQ-035 SHALL check: clr or rst_n=0 one cycle after accepting 4000 -> acc_out=0000, cnt=0, in_ready=1 next cycle, no out_valid.
